// File: rtl/collision_ram_arbiter_if.sv
// Requester/RAM-side bundle for collision_ram_arbiter: per-requester request/coordinate lanes,
// one-hot grant/response strobes, and the collision RAM address/data pair.
interface collision_ram_arbiter_if #(
    parameter int N_REQ = 4
) ();
    logic [N_REQ-1:0]    req;
    logic [10*N_REQ-1:0] req_x;
    logic [10*N_REQ-1:0] req_y;
    logic [N_REQ-1:0]    grant;
    logic [N_REQ-1:0]    rsp_valid;
    logic                rsp_block;
    logic [19:0]         ram_addr;
    logic                ram_dout;

    modport master (
        output req, req_x, req_y, ram_dout,
        input  grant, rsp_valid, rsp_block, ram_addr
    );

    modport slave (
        input  req, req_x, req_y, ram_dout,
        output grant, rsp_valid, rsp_block, ram_addr
    );
endinterface

// File: rtl/collision_ram_arbiter.sv
// Round-robin arbiter sharing a 1-bit collision RAM among N_REQ movers, one lookup in flight.
// Optional macro COLLISION_ARB_BOUNDS_EN forces out-of-map lookups to report blocked.
module collision_ram_arbiter #(
    parameter int N_REQ   = 4,
    parameter int MAP_W   = 960,
    parameter int MAP_H   = 500,
    parameter int RAM_LAT = 1
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    collision_ram_arbiter_if.slave bus
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    if (N_REQ < 2 || N_REQ > 8 || RAM_LAT < 1 || RAM_LAT > 3 || MAP_W < 1 || MAP_H < 1) begin : g_bad_params
        $error("collision_ram_arbiter: parameter out of range");
    end

    state_t              state_r;
    state_t              state_s;
    logic [PW-1:0]       ptr_r;
    logic [PW-1:0]       win_r;
    logic [1:0]          cnt_r;
    logic [N_REQ-1:0]    grant_r;
    logic [N_REQ-1:0]    rsp_valid_r;
    logic                rsp_block_r;
    logic [19:0]         ram_addr_r;
    logic [PW-1:0]       pick_s;
    logic                found_s;
    logic [9:0]          sel_x_s;
    logic [9:0]          sel_y_s;
    logic [19:0]         addr_s;
`ifdef COLLISION_ARB_BOUNDS_EN
    logic                oob_s;
    logic                oob_r;
`endif

    function automatic logic [N_REQ-1:0] onehot(input logic [PW-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

    // Round-robin search starting at ptr; the first requester found wins.
    always_comb begin
        pick_s  = '0;
        found_s = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            logic [PW-1:0] idx;
            idx     = PW'((int'(ptr_r) + i) % N_REQ);
            pick_s  = (!found_s && bus.req[idx]) ? idx : pick_s;
            found_s = found_s | bus.req[idx];
        end
    end

    // Winner's coordinate and its linear RAM address, full 20-bit product.
    always_comb begin
        sel_x_s = bus.req_x[int'(pick_s)*10 +: 10];
        sel_y_s = bus.req_y[int'(pick_s)*10 +: 10];
        addr_s  = 20'(sel_x_s) + 20'(sel_y_s) * 20'(MAP_W);
`ifdef COLLISION_ARB_BOUNDS_EN
        oob_s   = (int'(sel_x_s) >= MAP_W) || (int'(sel_y_s) >= MAP_H);
`endif
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (found_s) state_s = WAIT;
                else         state_s = IDLE;
            end
            WAIT: begin
                if (cnt_r == 2'd0) state_s = RESP;
                else               state_s = WAIT;
            end
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_s;
    end

    // Datapath: grant/address capture, latency countdown, result capture, pointer advance.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r       <= '0;
            win_r       <= '0;
            cnt_r       <= 2'd0;
            grant_r     <= '0;
            rsp_valid_r <= '0;
            rsp_block_r <= 1'b0;
            ram_addr_r  <= 20'd0;
`ifdef COLLISION_ARB_BOUNDS_EN
            oob_r       <= 1'b0;
`endif
        end else begin
            grant_r     <= '0;
            rsp_valid_r <= '0;
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        grant_r <= onehot(pick_s);
                        win_r   <= pick_s;
                        cnt_r   <= 2'(RAM_LAT);
`ifdef COLLISION_ARB_BOUNDS_EN
                        // Out-of-map lookups leave the RAM address untouched.
                        oob_r   <= oob_s;
                        if (!oob_s) ram_addr_r <= addr_s;
                        else        ram_addr_r <= ram_addr_r;
`else
                        ram_addr_r <= addr_s;
`endif
                    end else begin
                        ram_addr_r <= ram_addr_r;
                    end
                end
                WAIT: begin
                    // Counter at zero means ram_dout now reflects the granted address.
                    if (cnt_r == 2'd0) begin
                        rsp_valid_r <= onehot(win_r);
`ifdef COLLISION_ARB_BOUNDS_EN
                        rsp_block_r <= oob_r ? 1'b1 : bus.ram_dout;
`else
                        rsp_block_r <= bus.ram_dout;
`endif
                    end else begin
                        cnt_r <= cnt_r - 2'd1;
                    end
                end
                RESP: begin
                    ptr_r <= (win_r == PW'(N_REQ - 1)) ? '0 : win_r + PW'(1);
                end
                default: begin
                    ptr_r <= '0;
                end
            endcase
        end
    end

    assign bus.grant     = grant_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_block = rsp_block_r;
    assign bus.ram_addr  = ram_addr_r;
endmodule

// File: tb/tb_collision_ram_arbiter.sv
// Scoreboard bench for collision_ram_arbiter: directed lookups push expected grants/responses,
// a negedge monitor pops and compares whenever grant or rsp_valid pulses.
module tb_collision_ram_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic [19:0] last_addr = 20'd0;

    typedef struct {
        int          idx;
        logic [19:0] addr;
        logic        blk;
        int          cyc;
    } exp_t;

    exp_t gq[$];
    exp_t rq[$];

    collision_ram_arbiter_if #(.N_REQ(4)) bus ();

    collision_ram_arbiter #(.N_REQ(4), .MAP_W(960), .MAP_H(500), .RAM_LAT(1)) dut (
        .sys_clk (clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic ram_fn(input logic [19:0] a);
        return (a == 20'd336244) || (a[2:0] == 3'd5);
    endfunction

    // Collision RAM model, one cycle read latency.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.ram_dout <= 1'b0;
        else        bus.ram_dout <= ram_fn(bus.ram_addr);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus.grant != 4'd0 && bus.rsp_valid != 4'd0)
                chk("grant_rsp_overlap", {bus.grant, bus.rsp_valid}, 32'd0);
            if (bus.grant != 4'd0) begin
                if (gq.size() == 0) begin
                    chk("grant_unexpected", 32'(bus.grant), 32'd0);
                end else begin
                    e = gq.pop_front();
                    chk("grant_onehot", 32'(bus.grant), 32'd1 << e.idx);
                    chk("grant_cycle", 32'(cyc), 32'(e.cyc));
                    chk("ram_addr", 32'(bus.ram_addr), 32'(e.addr));
                end
            end
            if (bus.rsp_valid != 4'd0) begin
                if (rq.size() == 0) begin
                    chk("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
                end else begin
                    e = rq.pop_front();
                    chk("rsp_onehot", 32'(bus.rsp_valid), 32'd1 << e.idx);
                    chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
                    chk("rsp_block", 32'(bus.rsp_block), 32'(e.blk));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic req_on(input int i, input logic [9:0] x, input logic [9:0] y);
        bus.req_x[i*10 +: 10] = x;
        bus.req_y[i*10 +: 10] = y;
        bus.req[i] = 1'b1;
    endtask

    task automatic req_off(input int i);
        bus.req[i] = 1'b0;
    endtask

    task automatic expect_lookup(input int i, input logic [9:0] x, input logic [9:0] y,
                                 input int gcyc, input bit oob, input bit with_rsp);
        exp_t e;
        logic [19:0] a;
        a = 20'(x) + 20'(y) * 20'd960;
        e.idx = i;
        e.cyc = gcyc;
        if (oob) begin
            e.addr = last_addr;
            e.blk  = 1'b1;
        end else begin
            e.addr    = a;
            e.blk     = ram_fn(a);
            last_addr = a;
        end
        gq.push_back(e);
        e.cyc = gcyc + 2;
        if (with_rsp) rq.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        bit bounds_oob;
`ifdef COLLISION_ARB_BOUNDS_EN
        bounds_oob = 1'b1;
`else
        bounds_oob = 1'b0;
`endif
        bus.req   = 4'd0;
        bus.req_x = 40'd0;
        bus.req_y = 40'd0;
        repeat (3) tick();
        chk("reset_grant", 32'(bus.grant), 32'd0);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_rsp_block", 32'(bus.rsp_block), 32'd0);
        chk("reset_ram_addr", 32'(bus.ram_addr), 32'd0);
        rst_n = 1'b1;
        tick();

        // Fairness: all four held, grants 0,1,2,3,0 every 4 cycles.
        c = cyc;
        req_on(0, 10'd5, 10'd0);
        req_on(1, 10'd10, 10'd1);
        req_on(2, 10'd21, 10'd2);
        req_on(3, 10'd0, 10'd3);
        expect_lookup(0, 10'd5, 10'd0, c + 1, 1'b0, 1'b1);
        expect_lookup(1, 10'd10, 10'd1, c + 5, 1'b0, 1'b1);
        expect_lookup(2, 10'd21, 10'd2, c + 9, 1'b0, 1'b1);
        expect_lookup(3, 10'd0, 10'd3, c + 13, 1'b0, 1'b1);
        expect_lookup(0, 10'd5, 10'd0, c + 17, 1'b0, 1'b1);
        go_to(c + 5);  req_off(1);
        go_to(c + 9);  req_off(2);
        go_to(c + 13); req_off(3);
        go_to(c + 17); req_off(0);
        go_to(c + 20);

        // Single lookup at (244,350) -> address 336244, blocked.
        c = cyc;
        req_on(0, 10'd244, 10'd350);
        expect_lookup(0, 10'd244, 10'd350, c + 1, 1'b0, 1'b1);
        go_to(c + 1); req_off(0);
        go_to(c + 4);

        // Pointer rotation: grant 1 leaves ptr = 2, then 4'b1010 grants 3 before 1.
        c = cyc;
        req_on(1, 10'd100, 10'd7);
        expect_lookup(1, 10'd100, 10'd7, c + 1, 1'b0, 1'b1);
        go_to(c + 1); req_off(1);
        go_to(c + 4);
        c = cyc;
        req_on(1, 10'd33, 10'd44);
        req_on(3, 10'd500, 10'd499);
        expect_lookup(3, 10'd500, 10'd499, c + 1, 1'b0, 1'b1);
        expect_lookup(1, 10'd33, 10'd44, c + 5, 1'b0, 1'b1);
        go_to(c + 1); req_off(3);
        go_to(c + 5); req_off(1);
        go_to(c + 8);

        // x = MAP_W: out of map when bounds checking is built in.
        c = cyc;
        req_on(2, 10'd960, 10'd0);
        expect_lookup(2, 10'd960, 10'd0, c + 1, bounds_oob, 1'b1);
        go_to(c + 1); req_off(2);
        go_to(c + 4);

        // Withdrawal: req[3] raised and dropped while requester 0 is in flight.
        c = cyc;
        req_on(0, 10'd7, 10'd9);
        expect_lookup(0, 10'd7, 10'd9, c + 1, 1'b0, 1'b1);
        go_to(c + 1); req_off(0);
        go_to(c + 2); req_on(3, 10'd1, 10'd1);
        go_to(c + 3); req_off(3);
        go_to(c + 8);

        // Reset in WAIT: lookup aborted, outputs cleared at once, no response.
        c = cyc;
        req_on(2, 10'd50, 10'd60);
        expect_lookup(2, 10'd50, 10'd60, c + 1, 1'b0, 1'b0);
        go_to(c + 1); req_off(2);
        go_to(c + 2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_block", 32'(bus.rsp_block), 32'd0);
        chk("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
        go_to(c + 4);
        rst_n = 1'b1;
        c = cyc;
        req_on(3, 10'd3, 10'd3);
        expect_lookup(3, 10'd3, 10'd3, c + 1, 1'b0, 1'b1);
        go_to(c + 1); req_off(3);
        go_to(c + 8);

        chk("grants_outstanding", 32'(gq.size()), 32'd0);
        chk("rsps_outstanding", 32'(rq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
